// File: rtl/os_systolic_engine.sv
// os_systolic_engine: output-stationary GEMM tile with on-chip input skew,
// run controller and row-serial drain of the stationary accumulators.
module os_systolic_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int S_WIDTH    = 4,
  parameter int S_HEIGHT   = 4,
  parameter int K_MAX      = 64,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int RW = S_HEIGHT > 1 ? $clog2(S_HEIGHT) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_nrst,
  input  logic                            i_start,
  input  logic [KW-1:0]                   i_k_len,
  input  logic                            i_signed,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [S_HEIGHT*DATA_WIDTH-1:0]  i_ifmap,
  input  logic [S_WIDTH*DATA_WIDTH-1:0]   i_weight,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [S_WIDTH*ACC_WIDTH-1:0]    o_psum,
  output logic [RW-1:0]                   o_row_idx,
  output logic                            o_last,
  output logic                            o_busy
);
  localparam int FW = $clog2(S_HEIGHT + S_WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d, cnt_q, cnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic            sgn_q, sgn_d;
  logic            start_ok, accept, row_last;
  assign start_ok = state_q == IDLE && i_start && i_k_len != '0;
  assign accept   = state_q == LOAD && i_in_valid;
  assign row_last = row_q == RW'(S_HEIGHT - 1);
  always_comb begin
    state_d = state_q;
    k_len_d = k_len_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (start_ok) begin
        state_d = LOAD;
        k_len_d = i_k_len > KW'(K_MAX) ? KW'(K_MAX) : i_k_len;
        sgn_d   = i_signed;
        cnt_d   = '0;
        fcnt_d  = '0;
        row_d   = '0;
      end
      LOAD: if (accept) begin
        cnt_d = cnt_q + KW'(1);
        if (cnt_d == k_len_q) state_d = FLUSH;
      end
      FLUSH: begin
        fcnt_d = fcnt_q + FW'(1);
        if (fcnt_q == FW'(S_HEIGHT + S_WIDTH - 2)) state_d = DRAIN;
      end
      DRAIN: if (i_out_ready) begin
        row_d = row_last ? '0 : row_q + RW'(1);
        if (row_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      k_len_q <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      row_q   <= row_d;
    end
  end
  logic [DATA_WIDTH-1:0] a_edge [S_HEIGHT];
  logic [DATA_WIDTH-1:0] b_edge [S_WIDTH];
  // Lane r (c) is delayed by r (c) cycles so operands of the same k meet in each PE.
  for (genvar r = 0; r < S_HEIGHT; r++) begin : g_askew
    logic [DATA_WIDTH-1:0] inj;
    assign inj = accept ? i_ifmap[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_d0
      assign a_edge[r] = inj;
    end else begin : g_dn
      logic [DATA_WIDTH-1:0] sk_q [r];
      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) for (int j = 0; j < r; j++) sk_q[j] <= '0;
        else begin
          sk_q[0] <= inj;
          for (int j = 1; j < r; j++) sk_q[j] <= sk_q[j-1];
        end
      end
      assign a_edge[r] = sk_q[r-1];
    end
  end
  for (genvar c = 0; c < S_WIDTH; c++) begin : g_bskew
    logic [DATA_WIDTH-1:0] inj;
    assign inj = accept ? i_weight[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_d0
      assign b_edge[c] = inj;
    end else begin : g_dn
      logic [DATA_WIDTH-1:0] sk_q [c];
      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) for (int j = 0; j < c; j++) sk_q[j] <= '0;
        else begin
          sk_q[0] <= inj;
          for (int j = 1; j < c; j++) sk_q[j] <= sk_q[j-1];
        end
      end
      assign b_edge[c] = sk_q[c-1];
    end
  end
  logic [DATA_WIDTH-1:0] a_w   [S_HEIGHT][S_WIDTH];
  logic [DATA_WIDTH-1:0] b_w   [S_HEIGHT][S_WIDTH];
  logic [ACC_WIDTH-1:0]  acc_w [S_HEIGHT][S_WIDTH];
  for (genvar r = 0; r < S_HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < S_WIDTH; c++) begin : g_pe
      logic [DATA_WIDTH-1:0]       a_in, b_in, a_q, b_q;
      logic [ACC_WIDTH-1:0]        acc_q;
      logic signed [DATA_WIDTH:0]  ax, bx;
      logic signed [2*DATA_WIDTH+1:0] prod;
      if (c == 0) begin : g_al
        assign a_in = a_edge[r];
      end else begin : g_ai
        assign a_in = a_w[r][c-1];
      end
      if (r == 0) begin : g_bt
        assign b_in = b_edge[c];
      end else begin : g_bi
        assign b_in = b_w[r-1][c];
      end
      // One extra bit lets a single signed multiplier serve both operand modes.
      assign ax   = {sgn_q & a_in[DATA_WIDTH-1], a_in};
      assign bx   = {sgn_q & b_in[DATA_WIDTH-1], b_in};
      assign prod = ax * bx;
      always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_in;
          b_q   <= b_in;
          acc_q <= start_ok ? '0 : acc_q + ACC_WIDTH'(prod);
        end
      end
      assign a_w[r][c]   = a_q;
      assign b_w[r][c]   = b_q;
      assign acc_w[r][c] = acc_q;
    end
  end
  logic [S_WIDTH*ACC_WIDTH-1:0] row_sel;
  always_comb begin
    row_sel = '0;
    for (int c = 0; c < S_WIDTH; c++) row_sel[c*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_q][c];
  end
  assign o_in_ready  = state_q == LOAD;
  assign o_out_valid = state_q == DRAIN;
  assign o_busy      = state_q != IDLE;
  assign o_psum      = o_out_valid ? row_sel : '0;
  assign o_row_idx   = o_out_valid ? row_q : '0;
  assign o_last      = o_out_valid && row_last;
endmodule

// File: tb/tb_os_systolic_engine.sv
// tb_os_systolic_engine: scenario tasks drive runs; a negedge monitor pops the
// expected-row queue on every result handshake.
module tb_os_systolic_engine;
  localparam int DW = 8, AW = 24, SW = 4, SH = 4, KM = 64;
  typedef struct {
    logic [SW*AW-1:0] psum;
    logic [1:0]       idx;
    logic             last;
  } row_t;
  logic clk = 1'b0, nrst = 1'b0, start = 1'b0, sgn = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [6:0]       k_len = '0;
  logic [SH*DW-1:0] ifmap = '0;
  logic [SW*DW-1:0] weight = '0;
  logic             in_ready, out_valid, last, busy;
  logic [SW*AW-1:0] psum;
  logic [1:0]       row_idx;
  int checks = 0, errors = 0;
  logic [DW-1:0] A [KM][SH];
  logic [DW-1:0] B [KM][SW];
  row_t sb[$];
  os_systolic_engine dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_k_len(k_len), .i_signed(sgn),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_ifmap(ifmap), .i_weight(weight),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_psum(psum), .o_row_idx(row_idx),
    .o_last(last), .o_busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    row_t e;
    if (nrst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_row: got idx=%0d psum=%h, required no row", row_idx, psum);
      end else begin
        e = sb.pop_front();
        if (psum !== e.psum || row_idx !== e.idx || last !== e.last) begin
          errors++;
          $display("FAIL sb_row: got idx=%0d last=%b psum=%h, required idx=%0d last=%b psum=%h",
                   row_idx, last, psum, e.idx, e.last, e.psum);
        end
      end
    end
  end
  task automatic push_expected(input int k, input bit s);
    for (int r = 0; r < SH; r++) begin
      row_t e;
      longint acc, a, b;
      e.psum = '0;
      for (int c = 0; c < SW; c++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          a = s ? longint'($signed(A[kk][r])) : longint'(A[kk][r]);
          b = s ? longint'($signed(B[kk][c])) : longint'(B[kk][c]);
          acc += a * b;
        end
        e.psum[c*AW +: AW] = acc[AW-1:0];
      end
      e.idx  = 2'(r);
      e.last = (r == SH - 1);
      sb.push_back(e);
    end
  endtask
  task automatic fill(input int k, input int amode, input int bmode);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < SH; r++) A[i][r] = amode < 0 ? DW'(i + r) : DW'(amode);
      for (int c = 0; c < SW; c++) B[i][c] = bmode < 0 ? DW'(c + 1) : DW'(bmode);
    end
  endtask
  task automatic do_start(input int k, input bit s);
    start = 1'b1; k_len = 7'(k); sgn = s;
    @(posedge clk); #1;
    start = 1'b0; k_len = '0; sgn = ~s;
  endtask
  task automatic feed(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int r = 0; r < SH; r++) ifmap[r*DW +: DW] = A[i][r];
      for (int c = 0; c < SW; c++) weight[c*DW +: DW] = B[i][c];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; ifmap = '1; weight = '1;
      if (i < n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask
  task automatic wait_idle(output bit timeout);
    int n = 0;
    while (busy && n < 300) begin @(posedge clk); #1; n++; end
    timeout = busy;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({busy, in_ready, out_valid, last, row_idx, psum} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b rdy=%b vld=%b psum=%h, required all 0", busy, in_ready, out_valid, psum);
    end
    @(posedge clk); #1; nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, in_ready, out_valid, last, row_idx, psum} !== '0) begin
      errors++; $display("FAIL reset_release: got busy=%b rdy=%b vld=%b psum=%h, required all 0", busy, in_ready, out_valid, psum);
    end
  endtask
  task automatic test_basic();
    int lat; bit to;
    fill(1, 1, -1);
    push_expected(1, 0);
    do_start(1, 0);
    checks++;
    if ({busy, in_ready} !== 2'b11) begin
      errors++; $display("FAIL basic_load: got busy=%b in_ready=%b, required 1 1", busy, in_ready);
    end
    feed(1, 0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_drop: got %b, required 0", in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat != SH + SW) begin
      errors++; $display("FAIL basic_latency: got %0d, required %0d", lat, SH + SW);
    end
    checks++;
    if (psum !== {24'd4, 24'd3, 24'd2, 24'd1}) begin
      errors++; $display("FAIL basic_row0: got %h, required 000004000003000002000001", psum);
    end
    wait_idle(to);
    checks++;
    if (to || sb.size() != 0) begin
      errors++; $display("FAIL basic_done: got busy=%b pending=%0d, required 0 0", busy, sb.size());
    end
  endtask
  task automatic test_signed();
    int lat; bit to;
    for (int s = 1; s >= 0; s--) begin
      fill(3, 8'hFF, 8'h02);
      push_expected(3, s[0]);
      do_start(3, s[0]);
      feed(3, 0);
      wait_valid(lat);
      checks++;
      if (psum[AW-1:0] !== (s ? 24'hFFFFFA : 24'd1530)) begin
        errors++; $display("FAIL signed_mode%0d_elem: got %h, required %h", s, psum[AW-1:0], s ? 24'hFFFFFA : 24'd1530);
      end
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
        errors++; $display("FAIL signed_mode%0d_done: got busy=%b pending=%0d, required 0 0", s, busy, sb.size());
      end
    end
  endtask
  task automatic test_bubbles();
    int lat; bit to;
    for (int g = 2; g >= 0; g -= 2) begin
      fill(4, -1, -1);
      push_expected(4, 0);
      do_start(4, 0);
      feed(4, g);
      wait_valid(lat);
      checks++;
      if (lat != SH + SW) begin
        errors++; $display("FAIL bubbles_gap%0d_latency: got %0d, required %0d", g, lat, SH + SW);
      end
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
        errors++; $display("FAIL bubbles_gap%0d_done: got busy=%b pending=%0d, required 0 0", g, busy, sb.size());
      end
    end
  endtask
  task automatic test_backpressure();
    int lat; bit to;
    logic [SW*AW-1:0] hold;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < SH; r++) A[i][r] = DW'($urandom_range(0, 255));
      for (int c = 0; c < SW; c++) B[i][c] = DW'($urandom_range(0, 255));
    end
    push_expected(2, 1);
    do_start(2, 1);
    start = 1'b1; k_len = 7'd7;
    feed(2, 0);
    wait_valid(lat);
    @(posedge clk); #1;
    out_ready = 1'b0;
    hold = psum;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (psum !== hold || row_idx !== 2'd1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL hold_row1: got vld=%b idx=%0d psum=%h, required 1 1 %h", out_valid, row_idx, psum, hold);
      end
    end
    start = 1'b0; k_len = '0; out_ready = 1'b1;
    wait_idle(to);
    @(posedge clk); #1;
    checks++;
    if (to || busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL hold_done: got busy=%b pending=%0d, required 0 0", busy, sb.size());
    end
  endtask
  task automatic test_reset_midrun();
    bit to;
    fill(8, 1, 1);
    do_start(8, 0);
    feed(3, 0);
    nrst = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, last, row_idx, psum} !== '0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b rdy=%b vld=%b psum=%h, required all 0", busy, in_ready, out_valid, psum);
    end
    @(posedge clk); #1; nrst = 1'b1;
    @(posedge clk); #1;
    push_expected(1, 0);
    do_start(1, 0);
    feed(1, 0);
    wait_idle(to);
    checks++;
    if (to || sb.size() != 0) begin
      errors++; $display("FAIL midrun_rerun: got busy=%b pending=%0d, required 0 0", busy, sb.size());
    end
  endtask
  task automatic test_long_and_zero();
    int lat; bit to;
    int lens [2] = '{64, 100};
    fill(KM, 8'hFF, 8'hFF);
    foreach (lens[i]) begin
      push_expected(KM, 0);
      do_start(lens[i], 0);
      feed(KM, 0);
      wait_valid(lat);
      checks++;
      if (lat != SH + SW || psum[AW-1:0] !== 24'd4161600) begin
        errors++; $display("FAIL long_k%0d: got lat=%0d elem=%0d, required %0d 4161600", lens[i], lat, psum[AW-1:0], SH + SW);
      end
      wait_idle(to);
      checks++;
      if (to || sb.size() != 0) begin
        errors++; $display("FAIL long_k%0d_done: got busy=%b pending=%0d, required 0 0", lens[i], busy, sb.size());
      end
    end
    do_start(0, 0);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL klen_zero: got busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_bubbles();
    test_backpressure();
    test_reset_midrun();
    test_long_and_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
